vscpu_io_bridge: RTL and testbench
==================================

VSCPU_IO_BRIDGE -- requirements
Module: vscpu_io_bridge

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3: TX FIFO depth is 2**DEPTH_LOG2 words.
REQ-002 SHALL have parameter TXDATA_ADDR, default 14'h3FFF: write-only address that pushes a word into the TX FIFO.
REQ-003 SHALL have parameter STATUS_ADDR, default 14'h3FFE: read-only FIFO status address.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cpu_wrEn  in  1  CPU write strobe.
REQ-007 cpu_addr  in  14  CPU word address.
REQ-008 cpu_wdata  in  32  CPU write data.
REQ-009 cpu_rdata  out  32  read data to CPU; valid one cycle after the address is presented.
REQ-010 ram_wrEn  out  1  RAM write strobe.
REQ-011 ram_addr  out  14  RAM address.
REQ-012 ram_wdata  out  32  RAM write data.
REQ-013 ram_rdata  in  32  RAM read data, synchronous, 1-cycle latency.
REQ-014 tx_valid  out  1  FIFO head word available.
REQ-015 tx_ready  in  1  consumer accepts the head word.
REQ-016 tx_data  out  32  FIFO head word.

Function
REQ-017 ram_addr/ram_wdata SHALL equal cpu_addr/cpu_wdata combinationally; ram_wrEn = cpu_wrEn AND NOT io_hit, where io_hit = (cpu_addr==TXDATA_ADDR or cpu_addr==STATUS_ADDR).
REQ-018 SHALL register io_sel_q <= (cpu_addr==STATUS_ADDR or cpu_addr==TXDATA_ADDR) and status_q <= status word every cycle; cpu_rdata = status_q if io_sel_q, else ram_rdata (read latency 1, matches RAM).
REQ-019 Status word: bit31 ovf (see REQ-031), bit30 full, bit29 empty, bits[DEPTH_LOG2:0] count, all other bits 0; a read of TXDATA_ADDR SHALL return 0.
REQ-020 Push SHALL occur when cpu_wrEn=1, cpu_addr=TXDATA_ADDR and (not full, or pop occurs in the same cycle); a push while full with no pop SHALL be dropped.
REQ-021 Pop SHALL occur when tx_valid=1 and tx_ready=1.
REQ-022 tx_valid SHALL be (count != 0) from registered state; a push into an empty FIFO SHALL raise tx_valid on the next cycle (no fall-through).
REQ-023 tx_data SHALL be the head entry and SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; when full, both SHALL be accepted.
REQ-025 Read and write pointers SHALL be DEPTH_LOG2 bits and SHALL wrap modulo depth; count SHALL be DEPTH_LOG2+1 bits, range 0..depth.
REQ-026 Order SHALL be strict FIFO; no word duplicated or lost except the drop in REQ-020.

Reset
REQ-027 When rst=0, pointers, count, io_sel_q, status_q and the ovf flag SHALL clear asynchronously; tx_valid SHALL be 0 and cpu_rdata SHALL follow ram_rdata.
REQ-028 Reset asserted mid-transfer SHALL discard all FIFO contents; no pop is signalled after the reset edge.
REQ-029 FIFO storage array SHALL not require reset.

Configuration
REQ-030 Macro VSCPU_IOB_OVF_STICKY_EN SHALL control the overflow flag.
REQ-031 With the macro: a dropped push SHALL set the sticky ovf bit (status bit31); a CPU write to STATUS_ADDR SHALL clear it; set and clear in the same cycle SHALL resolve to set.
REQ-032 Without the macro: bit31 SHALL read 0, and writes to STATUS_ADDR SHALL be ignored (no RAM write).

Verification
REQ-033 Reset, then write 0x11 to 14'h0010, read 14'h0010 -> ram_wrEn=1 on the write; cpu_rdata=0x11 one cycle after the read address; tx_valid stays 0.
REQ-034 Push 0xA, 0xB, 0xC with tx_ready=0 -> tx_valid=1 starting the cycle after the first push; tx_data=0xA held stable; status read = count 3, empty 0; ram_wrEn=0 on every push.
REQ-035 Push 9 words (depth 8) with tx_ready=0 -> 9th word dropped; full=1; ovf=1 with the macro, 0 without; draining yields words 1..8 in order.
REQ-036 Full FIFO, tx_ready=1 and a push in the same cycle -> head popped, new word accepted, count stays 8, ovf unchanged.
REQ-037 Push 3 words, pop 2, then push 8 more while draining continuously -> pointer wrap-around; output sequence exactly matches the input sequence.
REQ-038 Assert rst=0 with 5 words queued and tx_ready=1 -> tx_valid drops immediately; after release, status read = empty 1, count 0, ovf 0.

Source files
------------

// File: rtl/vscpu_io_bridge.sv
// CPU-to-RAM pass-through with a memory-mapped TX FIFO and status register.
// Optional sticky overflow flag enabled by defining VSCPU_IOB_OVF_STICKY_EN.
module vscpu_io_bridge #(
    parameter int          DEPTH_LOG2  = 3,
    parameter logic [13:0] TXDATA_ADDR = 14'h3FFF,
    parameter logic [13:0] STATUS_ADDR = 14'h3FFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wrEn,
    input  logic [13:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        ram_wrEn,
    output logic [13:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_data
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  io_sel_q, io_sel_d;
    logic [31:0]           status_q, status_d;
    logic [31:0]           status_word;
    logic                  tx_hit, st_hit, full, empty, push, pop, ovf_flag;

    assign tx_hit    = (cpu_addr == TXDATA_ADDR);
    assign st_hit    = (cpu_addr == STATUS_ADDR);
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;
    assign ram_wrEn  = cpu_wrEn && !(tx_hit || st_hit);

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign tx_valid  = !empty;
    assign tx_data   = mem[rd_ptr_q];
    assign pop       = tx_valid && tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = cpu_wrEn && tx_hit && (!full || pop);

    always_comb begin
        status_word               = '0;
        status_word[31]           = ovf_flag;
        status_word[30]           = full;
        status_word[29]           = empty;
        status_word[DEPTH_LOG2:0] = count_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        io_sel_d = tx_hit || st_hit;
        status_d = st_hit ? status_word : '0;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            io_sel_q <= 1'b0;
            status_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            io_sel_q <= io_sel_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= cpu_wdata;
    end

    // Status word is captured with the address, so it returns with RAM latency.
    assign cpu_rdata = io_sel_q ? status_q : ram_rdata;

`ifdef VSCPU_IOB_OVF_STICKY_EN
    logic ovf_q, ovf_d, drop, st_wr;

    assign drop  = cpu_wrEn && tx_hit && full && !pop;
    assign st_wr = cpu_wrEn && st_hit;

    always_comb begin
        ovf_d = ovf_q;
        if (drop)       ovf_d = 1'b1;
        else if (st_wr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf_q <= 1'b0;
        else      ovf_q <= ovf_d;
    end

    assign ovf_flag = ovf_q;
`else
    assign ovf_flag = 1'b0;
`endif

endmodule

// File: tb/tb_vscpu_io_bridge.sv
// Scoreboard bench for vscpu_io_bridge: RAM path, TX FIFO, status, overflow, reset.
module tb_vscpu_io_bridge;

    localparam logic [13:0] TXA = 14'h3FFF;
    localparam logic [13:0] STA = 14'h3FFE;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_wrEn = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        ram_wrEn;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;

    logic [31:0] ram [0:16383];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          mcount = 0;
    logic        movf = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic        s_ram_we, s_valid;
    logic [31:0] s_data;

    vscpu_io_bridge dut (
        .clk(clk), .rst(rst),
        .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wrEn) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    always @(negedge clk) begin
        if (rst && tx_valid && tx_ready) obs_q.push_back(tx_data);
    end

    function automatic logic [31:0] exp_status();
        logic [3:0] c;
        c = 4'(mcount);
        return {movf, (mcount == DEPTH), (mcount == 0), 25'b0, c};
    endfunction

    // One bus cycle: drive, update model, sample at negedge, return #1 after posedge.
    task automatic cycle(input logic we, input logic [13:0] a, input logic [31:0] d, input logic rdy);
        logic mpop, ok;
        cpu_wrEn = we; cpu_addr = a; cpu_wdata = d; tx_ready = rdy;
        mpop = rdy && (mcount != 0);
        ok = 1'b0;
        if (we && a == TXA) begin
            if (mcount < DEPTH || mpop) begin
                ok = 1'b1;
                exp_q.push_back(d);
            end else begin
`ifdef VSCPU_IOB_OVF_STICKY_EN
                movf = 1'b1;
`endif
            end
        end else if (we && a == STA) begin
            movf = 1'b0;
        end
        @(negedge clk);
        s_ram_we = ram_wrEn; s_valid = tx_valid; s_data = tx_data;
        @(posedge clk); #1;
        mcount = mcount + int'(ok) - int'(mpop);
        cpu_wrEn = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && mcount != 0; i++) cycle(1'b0, 14'h0, 32'h0, 1'b1);
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] st;
        ram[0] = 32'hDEAD_BEEF;
        cpu_addr = 14'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", tx_valid); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_rdata got=%h want=deadbeef", cpu_rdata); end
        rst = 1'b1;
        st = exp_status();
        cycle(1'b0, STA, 32'h0, 1'b0);
        checks++; if (cpu_rdata !== st) begin errors++; $display("FAIL reset_status got=%h want=%h", cpu_rdata, st); end
    endtask

    task automatic test_ram();
        cycle(1'b1, 14'h0010, 32'h11, 1'b0);
        checks++; if (s_ram_we !== 1'b1) begin errors++; $display("FAIL ram_wren got=%0b want=1", s_ram_we); end
        cycle(1'b0, 14'h0010, 32'h0, 1'b0);
        checks++; if (cpu_rdata !== 32'h11) begin errors++; $display("FAIL ram_read got=%h want=00000011", cpu_rdata); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ram_txvalid got=%0b want=0", tx_valid); end
    endtask

    task automatic test_push3();
        logic [31:0] st;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, TXA, 32'hA + i, 1'b0);
            checks++; if (s_ram_we !== 1'b0) begin errors++; $display("FAIL push_ramwe[%0d] got=%0b want=0", i, s_ram_we); end
            if (i == 0) begin
                checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL push_fallthrough got=%0b want=0", s_valid); end
            end
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL push_valid[%0d] got=%0b want=1", i, tx_valid); end
            checks++; if (tx_data !== 32'hA) begin errors++; $display("FAIL push_head[%0d] got=%h want=0000000a", i, tx_data); end
        end
        st = exp_status();
        cycle(1'b0, STA, 32'h0, 1'b0);
        checks++; if (cpu_rdata !== st || st !== 32'h0000_0003) begin errors++; $display("FAIL push_status got=%h want=00000003", cpu_rdata); end
        cycle(1'b0, TXA, 32'h0, 1'b0);
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL txdata_read got=%h want=0", cpu_rdata); end
        drain();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL push_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [31:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL push_order got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_overflow();
        logic [31:0] st;
        for (int i = 1; i <= 9; i++) cycle(1'b1, TXA, i, 1'b0);
        st = exp_status();
        cycle(1'b0, STA, 32'h0, 1'b0);
        checks++; if (cpu_rdata !== st) begin errors++; $display("FAIL ovf_status got=%h want=%h", cpu_rdata, st); end
`ifdef VSCPU_IOB_OVF_STICKY_EN
        checks++; if (cpu_rdata[31] !== 1'b1) begin errors++; $display("FAIL ovf_bit got=%0b want=1", cpu_rdata[31]); end
`else
        checks++; if (cpu_rdata[31] !== 1'b0) begin errors++; $display("FAIL ovf_bit got=%0b want=0", cpu_rdata[31]); end
`endif
        // full FIFO: pop and push in the same cycle
        cycle(1'b1, TXA, 32'h100, 1'b1);
        tx_ready = 1'b0;
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL fullpp_pop got=%0d want=1", obs_q.size()); end
        st = exp_status();
        cycle(1'b0, STA, 32'h0, 1'b0);
        checks++; if (cpu_rdata !== st || cpu_rdata[3:0] !== 4'd8) begin errors++; $display("FAIL fullpp_status got=%h want=%h", cpu_rdata, st); end
        cycle(1'b1, STA, 32'hFFFF_FFFF, 1'b0);
        checks++; if (s_ram_we !== 1'b0) begin errors++; $display("FAIL stwr_ramwe got=%0b want=0", s_ram_we); end
        st = exp_status();
        cycle(1'b0, STA, 32'h0, 1'b0);
        checks++; if (cpu_rdata !== st || cpu_rdata[31] !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%h want=%h", cpu_rdata, st); end
        drain();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [31:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL ovf_order got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) cycle(1'b1, TXA, 32'h200 + i, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 14'h0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, TXA, 32'h300 + i, 1'b1);
        drain();
        checks++; if (obs_q.size() != exp_q.size() || obs_q.size() != 11) begin errors++; $display("FAIL wrap_count got=%0d want=11", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [31:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL wrap_order got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [31:0] st;
        for (int i = 0; i < 5; i++) cycle(1'b1, TXA, 32'h400 + i, 1'b0);
        tx_ready = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%0b want=1", tx_valid); end
        rst = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%0b want=0", tx_valid); end
        mcount = 0; movf = 1'b0; exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tx_ready = 1'b0;
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rmid_pop got=%0d want=0", obs_q.size()); end
        st = exp_status();
        cycle(1'b0, STA, 32'h0, 1'b0);
        checks++; if (cpu_rdata !== st || st !== 32'h2000_0000) begin errors++; $display("FAIL rmid_status got=%h want=20000000", cpu_rdata); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_after got=%0b want=0", tx_valid); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_push3();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
